// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: funct3 codes,
// the M-extension funct7 selector, FSM state encoding and datapath width.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the shared unsigned datapath: shift-add for multiply,
// restoring subtract for divide. acc holds {hi, lo} of product or {remainder, quotient}.
module muldiv_iter_step
    import muldiv_pkg::*;
(
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   operand_i,
    input  logic              div_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] pr;
    logic [XLEN:0] diff;

    always_comb begin
        sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        // Partial remainder gets the next dividend bit shifted in; a borrow means restore.
        pr   = acc_i[2*XLEN-1:XLEN-1];
        diff = pr - {1'b0, operand_i};
        if (!div_i) begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = {pr[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle RV32M sequencer beside the EX ALU; stalls the pipeline while busy.
// Define MULDIV_FAST_MUL_EN to resolve MUL* combinationally at accept (divide unchanged).
module ex_muldiv_sequencer #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            stall_req,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(ITER);

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   opnd_q;
    logic [2:0]        f3_q;
    logic              neg_q;
    logic [XLEN-1:0]   result_q;
    logic              rv_q;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              neg_d;

    // Datapath works on magnitudes; neg_d records the single fixup applied at the end.
    always_comb begin
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg    = a_signed & op_a[XLEN-1];
        b_neg    = b_signed & op_b[XLEN-1];
        mag_a    = a_neg ? -op_a : op_a;
        mag_b    = b_neg ? -op_b : op_b;
        if (funct3[2] && funct3[1]) begin
            neg_d = a_neg;
        end else if (funct3[2]) begin
            neg_d = (a_neg ^ b_neg) & (op_b != '0);
        end else begin
            neg_d = a_neg ^ b_neg;
        end
    end

    function automatic logic [XLEN-1:0] select_result(input logic [2:0]        f3,
                                                      input logic [2*XLEN-1:0] acc,
                                                      input logic              neg);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (f3)
            F3_MUL:                       return prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: return prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              return quo;
            default:                      return rem;
        endcase
    endfunction

`ifdef MULDIV_FAST_MUL_EN
    // Low 64 bits of the 65x65 signed product, formed with 64-bit sign extension.
    logic signed [2*XLEN-1:0] fa, fb, fprod;
    assign fa    = {{XLEN{a_signed & op_a[XLEN-1]}}, op_a};
    assign fb    = {{XLEN{b_signed & op_b[XLEN-1]}}, op_b};
    assign fprod = fa * fb;
`endif

    muldiv_iter_step u_step (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .div_i     (f3_q[2]),
        .acc_o     (acc_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            rv_q     <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            if (kill) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            f3_q   <= funct3;
                            neg_q  <= neg_d;
                            opnd_q <= mag_b;
                            acc_q  <= {{XLEN{1'b0}}, mag_a};
                            cnt_q  <= CW'(ITER - 1);
`ifdef MULDIV_FAST_MUL_EN
                            if (!funct3[2]) begin
                                result_q <= select_result(funct3, fprod, 1'b0);
                                rv_q     <= 1'b1;
                                state_q  <= S_DONE;
                            end else begin
                                state_q  <= S_BUSY;
                            end
`else
                            state_q <= S_BUSY;
`endif
                        end
                    end
                    S_BUSY: begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0) begin
                            result_q <= select_result(f3_q, acc_step, neg_q);
                            rv_q     <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // The stall covers the accept cycle itself; a flush releases it immediately.
    assign stall_req    = ~kill & ((start & (state_q == S_IDLE)) | (state_q == S_BUSY));
    assign busy         = (state_q != S_IDLE);
    assign result       = result_q;
    assign result_valid = rv_q & ~kill;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed self-checking bench for ex_muldiv_sequencer (default or MULDIV_FAST_MUL_EN build).
module tb_ex_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        stall_req, busy, result_valid;
    logic [31:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    always #5 clk = ~clk;

    ex_muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .kill         (kill),
        .stall_req    (stall_req),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    // Issues one op and holds start until the result strobe; reports what it saw.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls,
                          output logic stall_done);
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        #1;
        stalls = stall_req ? 1 : 0;
        lat = -1; res = 'x; stall_done = 1'bx;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #2;
            if (result_valid) begin
                lat = c; res = result; stall_done = stall_req;
                break;
            end
            if (stall_req) stalls++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_req); end
        n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %b want 0", result_valid); end
        n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_mul();
        logic [31:0] res; int lat, st; logic sd;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, res, lat, st, sd);
        n_cmp++; if (res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result got %h want ffffffeb", res); end
        n_cmp++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mul_latency got %0d want %0d", lat, MUL_LAT); end
        n_cmp++; if (st !== MUL_LAT) begin n_fail++; $display("FAIL mul_stall_cycles got %0d want %0d", st, MUL_LAT); end
        n_cmp++; if (sd !== 1'b0) begin n_fail++; $display("FAIL mul_stall_in_done got %b want 0", sd); end
    endtask

    task automatic test_mulh();
        logic [2:0]  f3 [3] = '{3'b011, 3'b001, 3'b010};
        logic [31:0] a  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
        logic [31:0] ex [3] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
        logic [31:0] res; int lat, st; logic sd;
        for (int i = 0; i < 3; i++) begin
            run_op(f3[i], a[i], b[i], res, lat, st, sd);
            n_cmp++; if (res !== ex[i]) begin n_fail++; $display("FAIL mulh_result[%0d] got %h want %h", i, res, ex[i]); end
            n_cmp++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mulh_latency[%0d] got %0d want %0d", i, lat, MUL_LAT); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3 [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] a  [4] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100, 32'd100};
        logic [31:0] b  [4] = '{32'd3, 32'd3, 32'd7, 32'd7};
        logic [31:0] ex [4] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'd14, 32'd2};
        logic [31:0] res; int lat, st; logic sd;
        for (int i = 0; i < 4; i++) begin
            run_op(f3[i], a[i], b[i], res, lat, st, sd);
            n_cmp++; if (res !== ex[i]) begin n_fail++; $display("FAIL div_result[%0d] got %h want %h", i, res, ex[i]); end
            n_cmp++; if (lat !== DIV_LAT) begin n_fail++; $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, DIV_LAT); end
        end
        n_cmp++; if (st !== DIV_LAT) begin n_fail++; $display("FAIL div_stall_cycles got %0d want %0d", st, DIV_LAT); end
    endtask

    task automatic test_div_corner();
        logic [2:0]  f3 [6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] a  [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFB};
        logic [31:0] b  [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] ex [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB};
        logic [31:0] res; int lat, st; logic sd;
        for (int i = 0; i < 6; i++) begin
            run_op(f3[i], a[i], b[i], res, lat, st, sd);
            n_cmp++; if (res !== ex[i]) begin n_fail++; $display("FAIL div_corner_result[%0d] got %h want %h", i, res, ex[i]); end
            n_cmp++; if (lat !== DIV_LAT) begin n_fail++; $display("FAIL div_corner_latency[%0d] got %0d want %0d", i, lat, DIV_LAT); end
        end
    endtask

    task automatic test_kill();
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        kill = 1'b1; start = 1'b0;
        #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL kill_stall_drop got %b want 0", stall_req); end
        @(posedge clk); #1;
        kill = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got %b want 0", busy); end
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        cyc = 12;
        while (cyc < 70) begin
            @(posedge clk); #2;
            cyc++;
            if (result_valid) break;
        end
        n_cmp++; if (cyc !== 45) begin n_fail++; $display("FAIL kill_restart_cycle got %0d want 45", cyc); end
        n_cmp++; if (result !== 32'd14) begin n_fail++; $display("FAIL kill_restart_result got %h want 0000000e", result); end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; int lat, st; logic sd;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b101; op_a = 32'd81; op_b = 32'd9;
        repeat (5) begin @(posedge clk); #1; end
        reset_n = 1'b0; start = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
        n_cmp++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL midreset_stall got %b want 0", stall_req); end
        n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL midreset_result got %h want 0", result); end
        n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_rv got %b want 0", result_valid); end
        @(negedge clk); reset_n = 1'b1;
        run_op(3'b000, 32'd3, 32'd4, res, lat, st, sd);
        n_cmp++; if (res !== 32'd12) begin n_fail++; $display("FAIL midreset_mul_result got %h want 0000000c", res); end
        n_cmp++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL midreset_mul_latency got %0d want %0d", lat, MUL_LAT); end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_corner();
        test_kill();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
